clock_divider: RTL and testbench
================================

Name: clock_divider

Overview:
- Programmable integer clock divider producing a slow square-wave clock from the system clock.
- Its output period is set at runtime by a divisor input.
- Used by the APU square channel to generate the sweep-unit clock, with divisor = 14920 × (1 + sweep period index), i.e. 14920..119360.
- The output is a registered, glitch-free level, suitable for driving posedge logic.

Parameters:
- WIDTH, 17, bit width of the divisor input and internal counter. Must hold 119360.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- div  input  WIDTH  divide ratio N, unsigned; output period = N clk cycles.
- clk_out  output  1  divided clock, registered.
- tick  output  1  present only when CLKDIV_TICK_EN is defined; see Optional Feature.

Behaviour:
- State: down-counter cnt[WIDTH-1:0], latched divisor div_q[WIDTH-1:0], output register clk_out.
- Reset (rst_n=0, asynchronous): cnt=0, div_q=2, clk_out=0 (and tick=0 when enabled). These values hold while rst_n is low.
- Effective divisor: div_eff = (div < 2) ? 2 : div. Values 0 and 1 behave exactly as 2.
- Each rising clk edge with rst_n=1:
  - Reload, when cnt == 0: div_q <= div_eff; cnt <= div_eff − 1; clk_out <= 1.
  - Otherwise: cnt <= cnt − 1; clk_out <= ((cnt − 1) >= (div_q >> 1)).
- Resulting waveform:
  - Period = div_q cycles.
  - High phase = ceil(div_q/2) cycles; low phase = floor(div_q/2) cycles.
  - Even N gives exactly 50% duty; odd N is high one cycle longer than low.
- Latency: the first clk_out rising edge occurs on the first clk edge after rst_n deasserts. Subsequent rising edges follow every div_q cycles.
- Divisor changes:
  - div is sampled only at reload. A mid-period change does not affect the current period or its high/low split; the new value takes effect at the next reload.
  - No truncated or runt pulses.
- Wrap-around: the counter never underflows; reload occurs exactly at cnt == 0.
- Reset mid-period: all state is abandoned immediately and clk_out drops low asynchronously. The restart is identical to power-on.
- All arithmetic is unsigned at WIDTH bits. div_eff − 1 never underflows because div_eff ≥ 2.
- No combinational path from div to clk_out.

Optional Feature:
- Macro CLKDIV_TICK_EN.
- Defined: adds output port tick (1 bit, registered).
  - tick = 1 for exactly one clk cycle, in the same cycle that clk_out rises (the reload edge); 0 otherwise.
  - Reset value 0.
  - Lets synchronous consumers use a clock enable instead of clocking on clk_out.
- Undefined: tick port and its register do not exist; clk_out behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with div=4 and toggle clk → clk_out=0 and tick=0 throughout. Assert rst_n asynchronously mid-cycle → clk_out goes 0 immediately.
- Even divide: div=4, release reset → clk_out sequence 1,1,0,0 repeating, starting on the first clk edge; tick=1 on cycles 1, 5, 9, ….
- Odd divide: div=3 → clk_out 1,1,0 repeating. div=0 and div=1 → 1,0 repeating, same as div=2.
- Mid-period change: div=8 running; change div to 2 two cycles after a rising edge → current period completes as 4 high, 4 low; afterwards 1,0 alternation. No runt pulse.
- Sweep ratio: div=14920 → rising edges exactly 14920 cycles apart, high 7460 / low 7460. div=119360 → edges 119360 cycles apart, with no counter overflow at WIDTH=17.
- Reset mid-operation: div=10; pulse rst_n low at cnt=5 → after release, first clk_out rise on the first clk edge, then a full 5-high/5-low period.

Source files
------------

// File: rtl/clock_divider.sv
// Programmable integer divider: clk_out period = max(div,2) clk cycles, high phase = ceil/low = floor.
// Latency: clk_out rises on the first clk edge after reset release; div is sampled only at each reload.
// No backpressure; optional one-cycle reload strobe 'tick' when CLKDIV_TICK_EN is defined.
module clock_divider #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] div,
`ifdef CLKDIV_TICK_EN
  output logic             tick,
`endif
  output logic             clk_out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             clk_out_q, clk_out_d;
  logic [WIDTH-1:0] div_eff;
  logic [WIDTH-1:0] cnt_dec;
  logic             reload;

  // Ratios below 2 cannot form a square wave, so they alias to 2.
  assign div_eff = (div < TWO) ? TWO : div;
  assign cnt_dec = cnt_q - ONE;
  assign reload  = (cnt_q == '0);

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    clk_out_d = clk_out_q;
    if (reload) begin
      div_d     = div_eff;
      cnt_d     = div_eff - ONE;
      clk_out_d = 1'b1;
    end else begin
      cnt_d     = cnt_dec;
      clk_out_d = (cnt_dec >= (div_q >> 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      div_q     <= TWO;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;

`ifdef CLKDIV_TICK_EN
  logic tick_q, tick_d;

  assign tick_d = reload;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider against a phase-position reference model.
module tb_clock_divider;

  localparam int WIDTH = 17;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] div;
  logic             clk_out;
  logic             tick;

  int n_tests;
  int n_fail;

  // Reference model: position within the current period and that period's ratio.
  int  m_phase;
  int  m_n;
  logic exp_clk;
  logic exp_tick;

  clock_divider #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .div     (div),
`ifdef CLKDIV_TICK_EN
    .tick    (tick),
`endif
    .clk_out (clk_out)
  );

`ifndef CLKDIV_TICK_EN
  assign tick = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int eff(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_n      = 2;
    exp_clk  = 1'b0;
    exp_tick = 1'b0;
  endtask

  // Advance the model by one clk edge using the divisor present at that edge.
  task automatic model_edge(input int d);
    if (m_phase == 0) m_n = eff(d);
    exp_clk  = (m_phase < (m_n + 1) / 2);
    exp_tick = (m_phase == 0);
    m_phase  = (m_phase + 1) % m_n;
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    rst_n = 1'b0;
    div   = WIDTH'(d);
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    div   = WIDTH'(4);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (clk_out !== 1'b0 || tick !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d clk_out=%b tick=%b want 0/0", i, clk_out, tick);
      end
    end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    @(posedge clk);
    model_edge(4);
    #1;
    n_tests++;
    if (clk_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_rise clk_out=%b want 1", clk_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (clk_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_drop clk_out=%b want 0", clk_out);
    end
  endtask

  task automatic test_even_divide();
    do_reset(4);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk);
      model_edge(4);
      #1;
      n_tests++;
      if (clk_out !== exp_clk) begin
        n_fail++;
        $display("FAIL even4 cyc=%0d clk_out=%b want %b", i, clk_out, exp_clk);
      end
`ifdef CLKDIV_TICK_EN
      n_tests++;
      if (tick !== exp_tick) begin
        n_fail++;
        $display("FAIL even4_tick cyc=%0d tick=%b want %b", i, tick, exp_tick);
      end
`endif
    end
  endtask

  task automatic test_odd_and_small();
    int ratios [4];
    ratios = '{3, 0, 1, 2};
    for (int r = 0; r < 4; r++) begin
      do_reset(ratios[r]);
      for (int i = 1; i <= 12; i++) begin
        @(posedge clk);
        model_edge(ratios[r]);
        #1;
        n_tests++;
        if (clk_out !== exp_clk) begin
          n_fail++;
          $display("FAIL small_div div=%0d cyc=%0d clk_out=%b want %b",
                   ratios[r], i, clk_out, exp_clk);
        end
      end
    end
  endtask

  task automatic test_mid_change();
    // Fixed expectation: 8-cycle period completes 4/4, then 1,0 alternation.
    logic [13:0] want;
    want = 14'b1111_0000_101010;
    do_reset(8);
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      model_edge(int'(div));
      #1;
      n_tests++;
      if (clk_out !== want[14 - i]) begin
        n_fail++;
        $display("FAIL mid_change cyc=%0d clk_out=%b want %b", i, clk_out, want[14 - i]);
      end
      if (i == 3) div = WIDTH'(2);
    end
  endtask

  task automatic test_sweep_ratio();
    int high_cnt, low_cnt, period, cyc;
    logic prev;
    do_reset(14920);
    high_cnt = 0; low_cnt = 0; period = 0; cyc = 0;
    prev = 1'b0;
    // Bounded walk from the first rise to the second rise.
    while (cyc < 16000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 1 && clk_out && !prev) begin
        period = cyc - 1;
        break;
      end
      if (clk_out) high_cnt++; else low_cnt++;
      prev = clk_out;
    end
    n_tests++;
    if (period !== 14920) begin
      n_fail++;
      $display("FAIL sweep_period got=%0d want 14920", period);
    end
    n_tests++;
    if (high_cnt !== 7460 || low_cnt !== 7460) begin
      n_fail++;
      $display("FAIL sweep_duty high=%0d low=%0d want 7460/7460", high_cnt, low_cnt);
    end

    do_reset(119360);
    low_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!clk_out) low_cnt++;
    end
    n_tests++;
    if (low_cnt !== 0) begin
      n_fail++;
      $display("FAIL max_ratio_high_phase lows=%0d want 0", low_cnt);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset(10);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (clk_out !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_drop clk_out=%b want 0", clk_out);
    end
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk);
      model_edge(10);
      #1;
      n_tests++;
      if (clk_out !== exp_clk) begin
        n_fail++;
        $display("FAIL midop_restart cyc=%0d clk_out=%b want %b", i, clk_out, exp_clk);
      end
    end
  endtask

  task automatic test_random();
    do_reset(int'($urandom_range(0, 12)));
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      model_edge(int'(div));
      #1;
      n_tests++;
      if (clk_out !== exp_clk) begin
        n_fail++;
        $display("FAIL random cyc=%0d div=%0d clk_out=%b want %b", i, div, clk_out, exp_clk);
      end
`ifdef CLKDIV_TICK_EN
      n_tests++;
      if (tick !== exp_tick) begin
        n_fail++;
        $display("FAIL random_tick cyc=%0d tick=%b want %b", i, tick, exp_tick);
      end
`endif
      if ($urandom_range(0, 9) == 0) div = WIDTH'($urandom_range(0, 12));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    div     = '0;
    model_reset();
    test_reset();
    test_even_divide();
    test_odd_and_small();
    test_mid_change();
    test_sweep_ratio();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
